// File: rtl/stack_port_arbiter.sv
// rtl/stack_port_arbiter.sv - two-requester round-robin arbiter and sequencer for the primitive stack
// Grants one transaction at a time, pre-checks occupancy and owns the stack data bus only while pushing.
module stack_port_arbiter #(
   parameter int DEPTH = 5,
   parameter int WIDTH = 4
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [1:0]       REQ,
   input  logic [1:0]       CMD0,
   input  logic [2:0]       IDX0,
   input  logic [WIDTH-1:0] WDATA0,
   input  logic [1:0]       CMD1,
   input  logic [2:0]       IDX1,
   input  logic [WIDTH-1:0] WDATA1,
   output logic [1:0]       ACK,
   output logic             ERR,
   output logic [WIDTH-1:0] RDATA,
   output logic             BUSY,
   output logic [2:0]       COUNT,
   output logic [1:0]       STK_COMMAND,
   output logic [2:0]       STK_INDEX,
   inout  wire  [WIDTH-1:0] STK_DATA
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ISSUE   = 2'd1;
   localparam logic [1:0] S_CAPTURE = 2'd2;
   localparam logic [1:0] S_RESP    = 2'd3;

   localparam logic [1:0] CMD_NOP  = 2'b00;
   localparam logic [1:0] CMD_PUSH = 2'b01;
   localparam logic [1:0] CMD_POP  = 2'b10;
   localparam logic [1:0] CMD_GET  = 2'b11;

   localparam logic [2:0] DEPTH_C = 3'(DEPTH);

   logic [1:0]       state_q, state_d;
   logic             grant_q, grant_d;
   logic             ptr_q, ptr_d;
   logic [1:0]       cmd_q, cmd_d;
   logic [2:0]       idx_q, idx_d;
   logic [WIDTH-1:0] wdata_q, wdata_d;
   logic             err_q, err_d;
   logic [2:0]       count_q, count_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic [WIDTH-1:0] cap_q, cap_d;

   logic             sel;
   logic [1:0]       sel_cmd;
   logic [2:0]       sel_idx;
   logic [WIDTH-1:0] sel_wdata;
   logic             sel_err;
   logic             is_read_q;
   logic             drive_bus;

   // A lone requester wins outright; the pointer only breaks ties.
   always_comb begin
      sel       = (REQ == 2'b11) ? ptr_q : REQ[1];
      sel_cmd   = sel ? CMD1 : CMD0;
      sel_idx   = sel ? IDX1 : IDX0;
      sel_wdata = sel ? WDATA1 : WDATA0;
      case (sel_cmd)
         CMD_POP:  sel_err = (count_q == 3'd0);
         CMD_PUSH: sel_err = (count_q == DEPTH_C);
         CMD_GET:  sel_err = (sel_idx >= count_q);
         default:  sel_err = 1'b0;
      endcase
   end

   assign is_read_q = (cmd_q == CMD_POP) || (cmd_q == CMD_GET);

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      cmd_d   = cmd_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      count_d = count_q;
      rdata_d = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (REQ != 2'b00) begin
               grant_d = sel;
               cmd_d   = sel_cmd;
               idx_d   = sel_idx;
               wdata_d = sel_wdata;
               err_d   = sel_err;
               state_d = (sel_err || (sel_cmd == CMD_NOP)) ? S_RESP : S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (cmd_q == CMD_PUSH) begin
               count_d = count_q + 3'd1;
            end else if (cmd_q == CMD_POP) begin
               count_d = count_q - 3'd1;
            end
            state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            // cap_q was loaded on the falling edge inside this cycle.
            if (is_read_q) begin
               rdata_d = cap_q;
            end
            state_d = S_RESP;
         end
         default: begin
            ptr_d   = ~grant_q;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= S_IDLE;
         grant_q <= 1'b0;
         ptr_q   <= 1'b0;
         cmd_q   <= CMD_NOP;
         idx_q   <= 3'd0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         count_q <= 3'd0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         cmd_q   <= cmd_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         count_q <= count_d;
         rdata_q <= rdata_d;
      end
   end

   // Stack read data is only guaranteed until the falling edge, so sample it there.
   always_comb begin
      cap_d = cap_q;
      if ((state_q == S_CAPTURE) && is_read_q) begin
         cap_d = STK_DATA;
      end
   end

   always_ff @(negedge CLK) begin
      cap_q <= cap_d;
   end

   assign drive_bus   = (state_q == S_ISSUE) && (cmd_q == CMD_PUSH);
   assign STK_DATA    = drive_bus ? wdata_q : {WIDTH{1'bz}};
   assign STK_COMMAND = (state_q == S_ISSUE) ? cmd_q : CMD_NOP;
   assign STK_INDEX   = (state_q == S_ISSUE) ? idx_q : 3'd0;

   assign ACK   = (state_q == S_RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
   assign ERR   = (state_q == S_RESP) && err_q;
   assign RDATA = rdata_q;
   assign BUSY  = (state_q != S_IDLE);
   assign COUNT = count_q;

endmodule

// File: tb/tb_stack_port_arbiter.sv
// tb/tb_stack_port_arbiter.sv - directed bench for stack_port_arbiter with a behavioural stack slave
module tb_stack_port_arbiter;

   logic       CLK = 1'b0;
   logic       RESET;
   logic [1:0] REQ;
   logic [1:0] CMD0, CMD1;
   logic [2:0] IDX0, IDX1;
   logic [3:0] WDATA0, WDATA1;
   logic [1:0] ACK;
   logic       ERR;
   logic [3:0] RDATA;
   logic       BUSY;
   logic [2:0] COUNT;
   logic [1:0] STK_COMMAND;
   logic [2:0] STK_INDEX;
   wire  [3:0] STK_DATA;

   int checks   = 0;
   int failures = 0;

   stack_port_arbiter #(.DEPTH(5), .WIDTH(4)) dut (
      .CLK(CLK), .RESET(RESET), .REQ(REQ),
      .CMD0(CMD0), .IDX0(IDX0), .WDATA0(WDATA0),
      .CMD1(CMD1), .IDX1(IDX1), .WDATA1(WDATA1),
      .ACK(ACK), .ERR(ERR), .RDATA(RDATA), .BUSY(BUSY), .COUNT(COUNT),
      .STK_COMMAND(STK_COMMAND), .STK_INDEX(STK_INDEX), .STK_DATA(STK_DATA)
   );

   always #5 CLK = ~CLK;

   // Stack slave: acts on the command seen during the previous cycle, drives read data until just past the falling edge.
   logic [3:0] mem [0:7];
   logic [2:0] sp      = 3'd0;
   logic [1:0] s_cmd   = 2'b00;
   logic [2:0] s_idx   = 3'd0;
   logic [3:0] s_data  = 4'd0;
   logic       stk_oe  = 1'b0;
   logic [3:0] stk_drv = 4'd0;

   assign STK_DATA = stk_oe ? stk_drv : 4'bzzzz;

   always @(negedge CLK) begin
      s_cmd  = STK_COMMAND;
      s_idx  = STK_INDEX;
      s_data = STK_DATA;
      #1 stk_oe = 1'b0;
   end

   always @(posedge CLK) begin
      if (RESET) begin
         sp     = 3'd0;
         stk_oe = 1'b0;
      end else begin
         case (s_cmd)
            2'b01: if (sp < 3'd5) begin mem[sp] = s_data; sp = sp + 3'd1; end
            2'b10: if (sp > 3'd0) begin stk_drv = mem[sp - 3'd1]; sp = sp - 3'd1; stk_oe = 1'b1; end
            2'b11: if (s_idx < sp) begin stk_drv = mem[sp - 3'd1 - s_idx]; stk_oe = 1'b1; end
            default: ;
         endcase
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      REQ = 2'b00;
      CMD0 = 2'b00; IDX0 = 3'd0; WDATA0 = 4'd0;
      CMD1 = 2'b00; IDX1 = 3'd0; WDATA1 = 4'd0;
      @(negedge CLK);
      @(negedge CLK);
      RESET = 1'b0;
   endtask

   // One transaction from requester r; REQ and payload are scrambled right after the grant edge.
   task automatic txn(input string tag, input int r, input logic [1:0] cmd, input logic [2:0] idx,
                      input logic [3:0] wd, input logic exp_err, input logic [3:0] exp_rdata,
                      input logic [2:0] exp_count);
      int         lat = 0;
      int         ncmd = 0;
      logic [1:0] cmd_seen = 2'b00;
      logic [2:0] idx_seen = 3'd0;
      logic [3:0] bus_seen = 4'd0;
      logic [1:0] ack_v = 2'b00;
      logic       err_v = 1'b0;
      logic [3:0] rd_v = 4'd0;
      logic       busy_v = 1'b0;
      logic       access;
      access = !exp_err && (cmd != 2'b00);
      if (r == 0) begin CMD0 = cmd; IDX0 = idx; WDATA0 = wd; end
      else        begin CMD1 = cmd; IDX1 = idx; WDATA1 = wd; end
      REQ[r] = 1'b1;
      for (int n = 1; n <= 10 && lat == 0; n++) begin
         @(negedge CLK);
         if (n == 1) begin
            REQ[r] = 1'b0;
            if (r == 0) begin CMD0 = ~cmd; IDX0 = ~idx; WDATA0 = ~wd; end
            else        begin CMD1 = ~cmd; IDX1 = ~idx; WDATA1 = ~wd; end
         end
         if (STK_COMMAND != 2'b00) begin
            ncmd++;
            cmd_seen = STK_COMMAND;
            idx_seen = STK_INDEX;
            if (STK_COMMAND == 2'b01) bus_seen = STK_DATA;
         end
         if (ACK != 2'b00) begin
            lat = n; ack_v = ACK; err_v = ERR; rd_v = RDATA; busy_v = BUSY;
         end
      end
      check({tag, ".ack"}, ack_v, (r == 0) ? 2'b01 : 2'b10);
      check({tag, ".latency"}, lat, access ? 3 : 1);
      check({tag, ".err"}, err_v, exp_err);
      check({tag, ".rdata"}, rd_v, exp_rdata);
      check({tag, ".count"}, COUNT, exp_count);
      check({tag, ".busy"}, busy_v, 1'b1);
      check({tag, ".stk_cycles"}, ncmd, access ? 1 : 0);
      if (access) begin
         check({tag, ".stk_cmd"}, cmd_seen, cmd);
         if (cmd == 2'b01) check({tag, ".stk_data"}, bus_seen, wd);
         if (cmd == 2'b11) check({tag, ".stk_idx"}, idx_seen, idx);
      end
      @(negedge CLK);
   endtask

   int         nack;
   int         ndat;
   int         ack_t [0:3];
   logic [1:0] ack_s [0:3];
   logic [3:0] dat_s [0:3];

   initial begin
      do_reset();
      check("rst.ack", ACK, 2'b00);
      check("rst.err", ERR, 1'b0);
      check("rst.rdata", RDATA, 4'h0);
      check("rst.busy", BUSY, 1'b0);
      check("rst.count", COUNT, 3'd0);
      check("rst.stk_cmd", STK_COMMAND, 2'b00);
      check("rst.stk_idx", STK_INDEX, 3'd0);

      txn("push_a", 0, 2'b01, 3'd0, 4'hA, 1'b0, 4'h0, 3'd1);

      // push 1,2,3 then read back from the other port
      do_reset();
      check("rst2.count", COUNT, 3'd0);
      txn("push1", 0, 2'b01, 3'd0, 4'h1, 1'b0, 4'h0, 3'd1);
      txn("push2", 0, 2'b01, 3'd0, 4'h2, 1'b0, 4'h0, 3'd2);
      txn("push3", 0, 2'b01, 3'd0, 4'h3, 1'b0, 4'h0, 3'd3);
      txn("pop_r1", 1, 2'b10, 3'd0, 4'h0, 1'b0, 4'h3, 3'd2);
      txn("get_i1", 0, 2'b11, 3'd1, 4'h0, 1'b0, 4'h1, 3'd2);
      txn("get_i0", 1, 2'b11, 3'd0, 4'h0, 1'b0, 4'h2, 3'd2);
      txn("nop_r1", 1, 2'b00, 3'd0, 4'h0, 1'b0, 4'h2, 3'd2);

      // underflow, fill to DEPTH, overflow, deepest legal and first illegal index
      do_reset();
      check("rst3.rdata", RDATA, 4'h0);
      check("rst3.count", COUNT, 3'd0);
      txn("pop_empty", 0, 2'b10, 3'd0, 4'h0, 1'b1, 4'h0, 3'd0);
      for (int i = 0; i < 5; i++)
         txn("fill", i % 2, 2'b01, 3'd0, 4'(i + 4), 1'b0, 4'h0, 3'(i + 1));
      txn("push_full", 1, 2'b01, 3'd0, 4'hF, 1'b1, 4'h0, 3'd5);
      txn("get_i4", 0, 2'b11, 3'd4, 4'h0, 1'b0, 4'h4, 3'd5);
      txn("get_i5", 1, 2'b11, 3'd5, 4'h0, 1'b1, 4'h4, 3'd5);

      // out-of-range GETs must leave RDATA alone
      do_reset();
      txn("push7", 0, 2'b01, 3'd0, 4'h7, 1'b0, 4'h0, 3'd1);
      txn("push9", 1, 2'b01, 3'd0, 4'h9, 1'b0, 4'h0, 3'd2);
      txn("get_top", 0, 2'b11, 3'd0, 4'h0, 1'b0, 4'h9, 3'd2);
      txn("get_i3", 0, 2'b11, 3'd3, 4'h0, 1'b1, 4'h9, 3'd2);
      txn("get_i6", 1, 2'b11, 3'd6, 4'h0, 1'b1, 4'h9, 3'd2);
      txn("get_i2", 0, 2'b11, 3'd2, 4'h0, 1'b1, 4'h9, 3'd2);
      txn("get_bot", 1, 2'b11, 3'd1, 4'h0, 1'b0, 4'h7, 3'd2);

      // both requesters hold REQ: grants alternate starting at 0
      do_reset();
      CMD0 = 2'b01; WDATA0 = 4'h1;
      CMD1 = 2'b01; WDATA1 = 4'h2;
      REQ = 2'b11;
      nack = 0;
      ndat = 0;
      for (int n = 1; n <= 40 && nack < 4; n++) begin
         @(negedge CLK);
         if (STK_COMMAND == 2'b01 && ndat < 4) begin dat_s[ndat] = STK_DATA; ndat++; end
         if (ACK != 2'b00) begin ack_s[nack] = ACK; ack_t[nack] = n; nack++; end
         if (nack == 4) REQ = 2'b00;
      end
      REQ = 2'b00;
      check("rr.acks", nack, 4);
      check("rr.pushes", ndat, 4);
      if (nack == 4 && ndat == 4) begin
         check("rr.first_lat", ack_t[0], 3);
         for (int i = 0; i < 4; i++) begin
            check($sformatf("rr.grant%0d", i), ack_s[i], (i % 2 == 0) ? 2'b01 : 2'b10);
            check($sformatf("rr.data%0d", i), dat_s[i], (i % 2 == 0) ? 4'h1 : 4'h2);
            if (i > 0) check($sformatf("rr.space%0d", i), ack_t[i] - ack_t[i-1], 4);
         end
      end
      check("rr.count", COUNT, 3'd4);
      @(negedge CLK);

      // reset lands while a POP is in CAPTURE
      do_reset();
      txn("push5", 0, 2'b01, 3'd0, 4'h5, 1'b0, 4'h0, 3'd1);
      CMD0 = 2'b10;
      REQ = 2'b01;
      @(negedge CLK);
      check("abort.issue_cmd", STK_COMMAND, 2'b10);
      REQ = 2'b00;
      @(negedge CLK);
      check("abort.capture_cmd", STK_COMMAND, 2'b00);
      check("abort.capture_busy", BUSY, 1'b1);
      RESET = 1'b1;
      @(negedge CLK);
      check("abort.ack", ACK, 2'b00);
      check("abort.count", COUNT, 3'd0);
      check("abort.stk_cmd", STK_COMMAND, 2'b00);
      check("abort.busy", BUSY, 1'b0);
      RESET = 1'b0;
      @(negedge CLK);
      check("abort.ack_later", ACK, 2'b00);
      txn("push_b", 0, 2'b01, 3'd0, 4'hB, 1'b0, 4'h0, 3'd1);
      txn("pop_b", 1, 2'b10, 3'd0, 4'h0, 1'b0, 4'hB, 3'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
